kv_req_arbiter: RTL and testbench

- Shares the single key-value DB lookup interface (in_key/in_flag/in_valid, with out_valid/out_flag returned) between two packet parsers, port 0 and port 1.
- Performs round-robin grant and tracks outstanding requests in an in-order tag FIFO, so each DB reply is routed back to the port that issued it.
- Recovers from a DB that stops replying by timing out and flushing all outstanding requests.
- Sits between the per-port parser/encap blocks and the DB core, in the clk156 domain.

---
 rtl/kv_req_arbiter_if.sv | 44 ++++
 rtl/kv_req_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_kv_req_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kv_req_arbiter_if.sv
// Request/reply bundle between the two parser ports, the arbiter and the KV DB core.
// The arbiter side uses modport slave; the parser/DB environment side uses modport master.
interface kv_req_arbiter_if #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_SIZE = 4
);
  logic                 p0_req_valid;
  logic                 p0_req_ready;
  logic [KEY_SIZE-1:0]  p0_req_key;
  logic [FLAG_SIZE-1:0] p0_req_flag;
  logic                 p0_rsp_valid;
  logic [FLAG_SIZE-1:0] p0_rsp_flag;

  logic                 p1_req_valid;
  logic                 p1_req_ready;
  logic [KEY_SIZE-1:0]  p1_req_key;
  logic [FLAG_SIZE-1:0] p1_req_flag;
  logic                 p1_rsp_valid;
  logic [FLAG_SIZE-1:0] p1_rsp_flag;

  logic [KEY_SIZE-1:0]  db_in_key;
  logic [FLAG_SIZE-1:0] db_in_flag;
  logic                 db_in_valid;
  logic                 db_out_valid;
  logic [FLAG_SIZE-1:0] db_out_flag;

  modport master (
    output p0_req_valid, p0_req_key, p0_req_flag,
    input  p0_req_ready, p0_rsp_valid, p0_rsp_flag,
    output p1_req_valid, p1_req_key, p1_req_flag,
    input  p1_req_ready, p1_rsp_valid, p1_rsp_flag,
    input  db_in_key, db_in_flag, db_in_valid,
    output db_out_valid, db_out_flag
  );

  modport slave (
    input  p0_req_valid, p0_req_key, p0_req_flag,
    output p0_req_ready, p0_rsp_valid, p0_rsp_flag,
    input  p1_req_valid, p1_req_key, p1_req_flag,
    output p1_req_ready, p1_rsp_valid, p1_rsp_flag,
    output db_in_key, db_in_flag, db_in_valid,
    input  db_out_valid, db_out_flag
  );
endinterface

// File: rtl/kv_req_arbiter.sv
// Round-robin sharing of one KV DB lookup port between two parsers, with in-order reply
// routing via a tag FIFO and timeout flush. Optional grant/timeout counters: KV_ARB_STATS_EN.
module kv_req_arbiter #(
  parameter int KEY_SIZE    = 96,
  parameter int FLAG_SIZE   = 4,
  parameter int OUTSTANDING = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic            clk156,
  input  logic            eth_rst_n,
  kv_req_arbiter_if.slave bus,
  output logic            err_timeout,
  output logic            err_spurious
`ifdef KV_ARB_STATS_EN
  ,
  output logic [31:0]     p0_grant_cnt,
  output logic [31:0]     p1_grant_cnt,
  output logic [15:0]     timeout_cnt
`endif
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0]      AGE_LIMIT = 16'(TIMEOUT);
  localparam logic [15:0]      AGE_MAX   = 16'hFFFF;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_QUIET = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [OUTSTANDING-1:0] tag_mem_r;
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 last_grant_r;
  logic [15:0]          age_r, age_s;

  logic                 fifo_empty_s, fifo_full_s, grant_en_s;
  logic                 grant0_s, grant1_s, push_s, pop_s, head_s;
  logic                 timeout_s, spurious_s;
  logic [FLAG_SIZE-1:0] rsp_flag_s;

  logic                 db_in_valid_r;
  logic [KEY_SIZE-1:0]  db_in_key_r;
  logic [FLAG_SIZE-1:0] db_in_flag_r;
  logic                 p0_rsp_valid_r, p1_rsp_valid_r;
  logic [FLAG_SIZE-1:0] p0_rsp_flag_r, p1_rsp_flag_r;
  logic                 err_timeout_r, err_spurious_r;

  assign fifo_empty_s = (count_r == '0);
  assign fifo_full_s  = (count_r == FULL_CNT);
  assign grant_en_s   = (state_r == ST_RUN) && !fifo_full_s;
  assign push_s       = grant0_s | grant1_s;
  assign head_s       = tag_mem_r[rd_ptr_r];

  assign bus.p0_req_ready = grant0_s;
  assign bus.p1_req_ready = grant1_s;
  assign bus.db_in_valid  = db_in_valid_r;
  assign bus.db_in_key    = db_in_key_r;
  assign bus.db_in_flag   = db_in_flag_r;
  assign bus.p0_rsp_valid = p0_rsp_valid_r;
  assign bus.p0_rsp_flag  = p0_rsp_flag_r;
  assign bus.p1_rsp_valid = p1_rsp_valid_r;
  assign bus.p1_rsp_flag  = p1_rsp_flag_r;
  assign err_timeout      = err_timeout_r;
  assign err_spurious     = err_spurious_r;

  // Round-robin winner: on a tie the port that did not win last time is granted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (grant_en_s) begin
      if (bus.p0_req_valid && bus.p1_req_valid) begin
        grant0_s = last_grant_r;
        grant1_s = ~last_grant_r;
      end else begin
        grant0_s = bus.p0_req_valid;
        grant1_s = bus.p1_req_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Next-state, pop decision, reply flag source and head-age update.
  always_comb begin
    state_s    = state_r;
    age_s      = age_r;
    pop_s      = 1'b0;
    rsp_flag_s = '0;
    timeout_s  = 1'b0;
    spurious_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (bus.db_out_valid) begin
          if (fifo_empty_s) begin
            spurious_s = 1'b1;
          end else begin
            pop_s      = 1'b1;
            rsp_flag_s = bus.db_out_flag;
          end
        end else if (!fifo_empty_s && (age_r >= AGE_LIMIT)) begin
          timeout_s = 1'b1;
          state_s   = ST_FLUSH;
        end else begin
          state_s = ST_RUN;
        end
        if (pop_s || fifo_empty_s) begin
          age_s = 16'd0;
        end else if (age_r != AGE_MAX) begin
          age_s = age_r + 16'd1;
        end else begin
          age_s = age_r;
        end
      end
      ST_FLUSH: begin
        // Synthetic replies carry flag 0; late DB replies are dropped here.
        age_s = 16'd0;
        if (fifo_empty_s) begin
          state_s = ST_QUIET;
        end else begin
          pop_s = 1'b1;
          if (count_r == ONE_CNT) begin
            state_s = ST_QUIET;
          end else begin
            state_s = ST_FLUSH;
          end
        end
      end
      ST_QUIET: begin
        age_s = age_r + 16'd1;
        if (age_s >= AGE_LIMIT) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_QUIET;
        end
      end
      default: begin
        state_s = ST_RUN;
        age_s   = 16'd0;
      end
    endcase
  end

  // State, age, round-robin pointer and tag FIFO storage.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state_r      <= ST_RUN;
      age_r        <= 16'd0;
      last_grant_r <= 1'b1;
      tag_mem_r    <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
    end else begin
      state_r <= state_s;
      age_r   <= age_s;
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= grant1_s;
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
        last_grant_r        <= grant1_s;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Registered DB request, per-port reply strobes and sticky error flags.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      db_in_valid_r  <= 1'b0;
      db_in_key_r    <= '0;
      db_in_flag_r   <= '0;
      p0_rsp_valid_r <= 1'b0;
      p1_rsp_valid_r <= 1'b0;
      p0_rsp_flag_r  <= '0;
      p1_rsp_flag_r  <= '0;
      err_timeout_r  <= 1'b0;
      err_spurious_r <= 1'b0;
    end else begin
      db_in_valid_r <= push_s;
      if (push_s) begin
        db_in_key_r  <= grant1_s ? bus.p1_req_key  : bus.p0_req_key;
        db_in_flag_r <= grant1_s ? bus.p1_req_flag : bus.p0_req_flag;
      end
      p0_rsp_valid_r <= pop_s && !head_s;
      p1_rsp_valid_r <= pop_s && head_s;
      if (pop_s && !head_s) begin
        p0_rsp_flag_r <= rsp_flag_s;
      end
      if (pop_s && head_s) begin
        p1_rsp_flag_r <= rsp_flag_s;
      end
      err_timeout_r  <= err_timeout_r | timeout_s;
      err_spurious_r <= err_spurious_r | spurious_s;
    end
  end

`ifdef KV_ARB_STATS_EN
  logic [31:0] p0_grant_cnt_r, p1_grant_cnt_r;
  logic [15:0] timeout_cnt_r;

  assign p0_grant_cnt = p0_grant_cnt_r;
  assign p1_grant_cnt = p1_grant_cnt_r;
  assign timeout_cnt  = timeout_cnt_r;

  // Free-running wrap-around statistics.
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      p0_grant_cnt_r <= 32'd0;
      p1_grant_cnt_r <= 32'd0;
      timeout_cnt_r  <= 16'd0;
    end else begin
      p0_grant_cnt_r <= p0_grant_cnt_r + 32'(grant0_s);
      p1_grant_cnt_r <= p1_grant_cnt_r + 32'(grant1_s);
      timeout_cnt_r  <= timeout_cnt_r + 16'(timeout_s);
    end
  end
`endif

endmodule

// File: tb/tb_kv_req_arbiter.sv
// Randomized scoreboard bench for kv_req_arbiter: a queue-based reference model predicts
// grants, DB requests and routed replies; a monitor compares what the DUT presents.
module tb_kv_req_arbiter;
  localparam int KS   = 96;
  localparam int FS   = 4;
  localparam int OUTS = 4;
  localparam int TMO  = 8;

  typedef struct {
    logic [KS-1:0] key;
    logic [FS-1:0] flag;
  } db_exp_t;

  typedef struct {
    bit            port;
    logic [FS-1:0] flag;
  } rsp_exp_t;

  logic clk156    = 1'b0;
  logic eth_rst_n = 1'b0;
  logic err_timeout, err_spurious;
`ifdef KV_ARB_STATS_EN
  logic [31:0] p0_grant_cnt, p1_grant_cnt;
  logic [15:0] timeout_cnt;
`endif

  kv_req_arbiter_if #(.KEY_SIZE(KS), .FLAG_SIZE(FS)) bus ();

  kv_req_arbiter #(.KEY_SIZE(KS), .FLAG_SIZE(FS), .OUTSTANDING(OUTS), .TIMEOUT(TMO)) dut (
    .clk156       (clk156),
    .eth_rst_n    (eth_rst_n),
    .bus          (bus),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious)
`ifdef KV_ARB_STATS_EN
    ,
    .p0_grant_cnt (p0_grant_cnt),
    .p1_grant_cnt (p1_grant_cnt),
    .timeout_cnt  (timeout_cnt)
`endif
  );

  always #5 clk156 = ~clk156;

  // Reference model: the outstanding list, arbitration memory and mode (0 run, 1 flush, 2 quiet).
  bit       m_fifo[$];
  db_exp_t  db_q[$];
  rsp_exp_t rsp_q[$];
  int       m_mode;
  bit       m_last;
  int       m_age;
  bit       m_err_to, m_err_sp;
  int       m_g0, m_g1, m_to;
  int       total, bad;
  bit       done;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_fifo.delete();
    db_q.delete();
    rsp_q.delete();
    m_mode   = 0;
    m_last   = 1'b1;
    m_age    = 0;
    m_err_to = 1'b0;
    m_err_sp = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.p0_req_valid = 1'b0;
    bus.p1_req_valid = 1'b0;
    bus.p0_req_key   = '0;
    bus.p1_req_key   = '0;
    bus.p0_req_flag  = '0;
    bus.p1_req_flag  = '0;
    bus.db_out_valid = 1'b0;
    bus.db_out_flag  = '0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus.db_in_valid, bus.p0_rsp_valid, bus.p1_rsp_valid, err_timeout, err_spurious,
                 bus.p0_req_ready, bus.p1_req_ready, bus.p0_rsp_flag, bus.p1_rsp_flag,
                 bus.db_in_flag, |bus.db_in_key}, 128'd0);
  endtask

  // One clock of stimulus. db_mode: 0 DB answers outstanding work, 1 silent, 2 random strobes.
  task automatic step(input int db_mode, input int vprob);
    bit v0, v1, dv, e0, e1, hd, was_empty;
    logic [KS-1:0] k0, k1;
    logic [FS-1:0] f0, f1, df;
    @(negedge clk156);
    check("db_missing", 128'(db_q.size()), 128'd0);
    check("rsp_missing", 128'(rsp_q.size()), 128'd0);
    db_q.delete();
    rsp_q.delete();
    v0 = $urandom_range(0, 99) < vprob;
    v1 = $urandom_range(0, 99) < vprob;
    k0 = {$urandom(), $urandom(), $urandom()};
    k1 = {$urandom(), $urandom(), $urandom()};
    f0 = FS'($urandom());
    f1 = FS'($urandom());
    df = FS'($urandom());
    case (db_mode)
      0: dv = (m_fifo.size() != 0) && ($urandom_range(0, 2) == 0);
      1: dv = 1'b0;
      default: dv = ($urandom_range(0, 3) == 0);
    endcase
    bus.p0_req_valid = v0;
    bus.p1_req_valid = v1;
    bus.p0_req_key   = k0;
    bus.p1_req_key   = k1;
    bus.p0_req_flag  = f0;
    bus.p1_req_flag  = f1;
    bus.db_out_valid = dv;
    bus.db_out_flag  = df;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (m_mode == 0 && m_fifo.size() < OUTS) begin
      if (v0 && v1) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    check("p0_ready", 128'(bus.p0_req_ready), 128'(e0));
    check("p1_ready", 128'(bus.p1_req_ready), 128'(e1));
    was_empty = (m_fifo.size() == 0);
    case (m_mode)
      0: begin
        if (dv && !was_empty) begin
          hd = m_fifo.pop_front();
          rsp_q.push_back('{port: hd, flag: df});
          m_age = 0;
        end else if (dv) begin
          m_err_sp = 1'b1;
          m_age = 0;
        end else if (!was_empty && m_age >= TMO) begin
          m_err_to = 1'b1;
          m_mode = 1;
          m_to++;
        end else if (was_empty) begin
          m_age = 0;
        end else begin
          m_age = (m_age < 65535) ? m_age + 1 : m_age;
        end
      end
      1: begin
        m_age = 0;
        if (!was_empty) begin
          hd = m_fifo.pop_front();
          rsp_q.push_back('{port: hd, flag: 4'd0});
        end
        if (m_fifo.size() == 0) m_mode = 2;
      end
      default: begin
        m_age++;
        if (m_age >= TMO) m_mode = 0;
      end
    endcase
    if (e0 || e1) begin
      m_fifo.push_back(e1);
      m_last = e1;
      db_q.push_back('{key: (e1 ? k1 : k0), flag: (e1 ? f1 : f0)});
      if (e1) m_g1++;
      else m_g0++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk156);
    check("db_missing_pre_rst", 128'(db_q.size()), 128'd0);
    check("rsp_missing_pre_rst", 128'(rsp_q.size()), 128'd0);
    idle_inputs();
    eth_rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    model_clear();
    repeat (2) @(negedge clk156);
    eth_rst_n = 1'b1;
  endtask

  // Monitor: whatever the DUT presents after an edge must match the head of the expected queues.
  initial begin
    db_exp_t  de;
    rsp_exp_t re;
    while (!done) begin
      @(posedge clk156);
      #1;
      if (bus.db_in_valid) begin
        if (db_q.size() == 0) begin
          check("db_unexpected", 128'd1, 128'd0);
        end else begin
          de = db_q.pop_front();
          check("db_key", 128'(bus.db_in_key), 128'(de.key));
          check("db_flag", 128'(bus.db_in_flag), 128'(de.flag));
        end
      end
      check("rsp_both_ports", 128'(bus.p0_rsp_valid && bus.p1_rsp_valid), 128'd0);
      if (bus.p0_rsp_valid || bus.p1_rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 128'd1, 128'd0);
        end else begin
          re = rsp_q.pop_front();
          check("rsp_port", 128'(bus.p1_rsp_valid), 128'(re.port));
          check("rsp_flag", 128'(bus.p1_rsp_valid ? bus.p1_rsp_flag : bus.p0_rsp_flag),
                128'(re.flag));
        end
      end
      check("err_timeout", 128'(err_timeout), 128'(m_err_to));
      check("err_spurious", 128'(err_spurious), 128'(m_err_sp));
    end
  end

  initial begin
    int guard;
    total = 0;
    bad   = 0;
    done  = 1'b0;
    m_g0  = 0;
    m_g1  = 0;
    m_to  = 0;
    idle_inputs();
    model_clear();
    #1;
    check_all_zero("reset_state");
    @(negedge clk156);
    eth_rst_n = 1'b1;

    repeat (300) step(0, 60);
    repeat (5)   step(1, 80);
    do_reset();
    repeat (100) step(0, 70);
    repeat (150) step(1, 50);
    repeat (60)  step(0, 90);
    repeat (200) step(2, 40);

    guard = 0;
    while ((m_fifo.size() != 0 || m_mode != 0) && guard < 200) begin
      step(0, 0);
      guard++;
    end
    check("drain_bounded", 128'(m_fifo.size() != 0 || m_mode != 0), 128'd0);
    repeat (2) step(1, 0);
`ifdef KV_ARB_STATS_EN
    check("p0_grant_cnt", 128'(p0_grant_cnt), 128'(32'(m_g0)));
    check("p1_grant_cnt", 128'(p1_grant_cnt), 128'(32'(m_g1)));
    check("timeout_cnt", 128'(timeout_cnt), 128'(16'(m_to)));
`endif
    done = 1'b1;
    @(posedge clk156);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bench-side statistics are reset with the DUT so that the optional counters compare.
  always @(negedge eth_rst_n) begin
    m_g0 = 0;
    m_g1 = 0;
    m_to = 0;
  end

endmodule
